// File: rtl/tile_pixel_renderer.sv
// Maze/sprite pixel compositor: 3-cycle fixed latency, no backpressure (one pixel per clock).
// Define RENDER_FRIGHT_EN to add the ghost_fright input (frightened ghost palette).
module tile_pixel_renderer #(
    parameter int TILE        = 16,
    parameter int MAP_W       = 28,
    parameter int MAP_H       = 31,
    parameter int ANIM_PERIOD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_valid,
    input  logic [9:0]             pix_x,
    input  logic [9:0]             pix_y,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    output logic [9:0]             map_addr,
    input  logic [1:0]             map_tile,
    input  logic [TILE*TILE-1:0]   player_mask_f1,
    input  logic [TILE*TILE-1:0]   player_mask_f2,
    input  logic [TILE*TILE-1:0]   ghost_mask_f1,
    input  logic [TILE*TILE-1:0]   ghost_mask_f2,
    input  logic [TILE*TILE-1:0]   dot_mask,
    input  logic [TILE*TILE-1:0]   big_dot_mask,
    input  logic [4*TILE*TILE-1:0] ghost_sclera_masks,
    input  logic [4*TILE*TILE-1:0] ghost_eye_masks,
    input  logic [9:0]             player_x,
    input  logic [9:0]             player_y,
    input  logic [9:0]             ghost_x,
    input  logic [9:0]             ghost_y,
    input  logic [1:0]             ghost_dir,
`ifdef RENDER_FRIGHT_EN
    input  logic                   ghost_fright,
`endif
    input  logic [11:0]            ghost_rgb,
    output logic [3:0]             vga_r,
    output logic [3:0]             vga_g,
    output logic [3:0]             vga_b,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   pix_valid_out
);
    localparam int TB = $clog2(TILE);
    localparam int CW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [9:0]    MAP_W_L = 10'(MAP_W);
    localparam logic [9:0]    MAP_H_L = 10'(MAP_H);
    localparam logic [10:0]   TILE_L  = 11'(TILE);
    localparam logic [CW-1:0] LAST    = CW'(ANIM_PERIOD - 1);

    typedef struct packed {
        logic          vld;
        logic          hs;
        logic          vs;
        logic          in_map;
        logic          anim;
        logic          fright;
        logic          p_hit;
        logic          g_hit;
        logic [1:0]    dir;
        logic [11:0]   grgb;
        logic [TB-1:0] u;
        logic [TB-1:0] v;
        logic [TB-1:0] pu;
        logic [TB-1:0] pv;
        logic [TB-1:0] gu;
        logic [TB-1:0] gv;
    } stage_t;

    logic [9:0]    sh_px_q, sh_py_q, sh_gx_q, sh_gy_q;
    logic [1:0]    sh_dir_q;
    logic [11:0]   sh_rgb_q;
    logic          sh_fr_q;
    logic          vs_prev_q, anim_q, vs_rise;
    logic [CW-1:0] frame_q;

    assign vs_rise = vsync_in & ~vs_prev_q;

    // Sprite state only moves on a frame boundary so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            sh_px_q   <= '0;
            sh_py_q   <= '0;
            sh_gx_q   <= '0;
            sh_gy_q   <= '0;
            sh_dir_q  <= '0;
            sh_rgb_q  <= '0;
            frame_q   <= '0;
            anim_q    <= 1'b0;
        end else begin
            vs_prev_q <= vsync_in;
            if (vs_rise) begin
                sh_px_q  <= player_x;
                sh_py_q  <= player_y;
                sh_gx_q  <= ghost_x;
                sh_gy_q  <= ghost_y;
                sh_dir_q <= ghost_dir;
                sh_rgb_q <= ghost_rgb;
                if (frame_q == LAST) begin
                    frame_q <= '0;
                    anim_q  <= ~anim_q;
                end else begin
                    frame_q <= frame_q + 1'b1;
                end
            end
        end
    end

`ifdef RENDER_FRIGHT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sh_fr_q <= 1'b0;
        else if (vs_rise) sh_fr_q <= ghost_fright;
    end
`else
    assign sh_fr_q = 1'b0;
`endif

    // 11-bit compare so sprites near the right/bottom edge clip instead of wrapping.
    function automatic logic hit(input logic [9:0] p, input logic [9:0] s);
        return ({1'b0, p} >= {1'b0, s}) && ({1'b0, p} < ({1'b0, s} + TILE_L));
    endfunction

    logic [9:0] col, row, map_addr_d, map_addr_q;
    logic       in_map;
    stage_t     s1_d, s1_q, s2_q;

    always_comb begin
        col        = 10'(pix_x >> TB);
        row        = 10'(pix_y >> TB);
        in_map     = pix_valid && (col < MAP_W_L) && (row < MAP_H_L);
        map_addr_d = in_map ? (row * MAP_W_L + col) : map_addr_q;
        s1_d        = '0;
        s1_d.vld    = pix_valid;
        s1_d.hs     = hsync_in;
        s1_d.vs     = vsync_in;
        s1_d.in_map = in_map;
        s1_d.anim   = anim_q;
        s1_d.fright = sh_fr_q;
        s1_d.p_hit  = pix_valid && hit(pix_x, sh_px_q) && hit(pix_y, sh_py_q);
        s1_d.g_hit  = pix_valid && hit(pix_x, sh_gx_q) && hit(pix_y, sh_gy_q);
        s1_d.dir    = sh_dir_q;
        s1_d.grgb   = sh_rgb_q;
        s1_d.u      = pix_x[TB-1:0];
        s1_d.v      = pix_y[TB-1:0];
        s1_d.pu     = pix_x[TB-1:0] - sh_px_q[TB-1:0];
        s1_d.pv     = pix_y[TB-1:0] - sh_py_q[TB-1:0];
        s1_d.gu     = pix_x[TB-1:0] - sh_gx_q[TB-1:0];
        s1_d.gv     = pix_y[TB-1:0] - sh_gy_q[TB-1:0];
    end

    logic [2*TB-1:0] t_idx, p_idx, g_idx;
    logic [1:0]      tile;
    logic            p_bit, g_body, g_eye, g_scl;
    logic [11:0]     rgb_d, rgb_q;
    logic            hs_q, vs_q, vld_q;

    // map_tile for the stage-2 pixel is on the bus now; it is only trusted inside the maze.
    always_comb begin
        t_idx  = {s2_q.v, s2_q.u};
        p_idx  = {s2_q.pv, s2_q.pu};
        g_idx  = {s2_q.gv, s2_q.gu};
        tile   = s2_q.in_map ? map_tile : 2'd0;
        p_bit  = s2_q.p_hit && (s2_q.anim ? player_mask_f2[p_idx] : player_mask_f1[p_idx]);
        g_body = s2_q.g_hit && (s2_q.anim ? ghost_mask_f2[g_idx] : ghost_mask_f1[g_idx]);
        g_eye  = s2_q.g_hit && ghost_eye_masks[{s2_q.dir, g_idx}];
        g_scl  = s2_q.g_hit && !s2_q.fright && ghost_sclera_masks[{s2_q.dir, g_idx}];
        rgb_d  = 12'h000;
        if (!s2_q.vld)                           rgb_d = 12'h000;
        else if (p_bit)                          rgb_d = 12'hFF0;
        else if (g_eye)                          rgb_d = s2_q.fright ? 12'hFB9 : 12'h22F;
        else if (g_scl)                          rgb_d = 12'hFFF;
        else if (g_body)                         rgb_d = s2_q.fright ? 12'h00F : s2_q.grgb;
        else if (tile == 2'd3 && big_dot_mask[t_idx]) rgb_d = 12'hFB9;
        else if (tile == 2'd2 && dot_mask[t_idx])     rgb_d = 12'hFB9;
        else if (tile == 2'd1)                   rgb_d = 12'h00F;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_addr_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            rgb_q      <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            map_addr_q <= map_addr_d;
            s1_q       <= s1_d;
            s2_q       <= s1_q;
            rgb_q      <= rgb_d;
            hs_q       <= s2_q.hs;
            vs_q       <= s2_q.vs;
            vld_q      <= s2_q.vld;
        end
    end

    assign map_addr      = map_addr_q;
    assign vga_r         = rgb_q[11:8];
    assign vga_g         = rgb_q[7:4];
    assign vga_b         = rgb_q[3:0];
    assign hsync_out     = hs_q;
    assign vsync_out     = vs_q;
    assign pix_valid_out = vld_q;
endmodule
